// File: rtl/msk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : msk_pkg
// Purpose  : Shared helpers for the masked DOM AND pipeline: randomness count
//            per lane, packed randomness index of a share pair, and the bit
//            position of a share inside a lane-major sharing vector.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package msk_pkg;

    // Number of fresh random bits one lane needs for d shares.
    function automatic int n_rnd(input int d);
        return d * (d - 1) / 2;
    endfunction

    // Position of pair (i,j), i<j, inside one lane's randomness field.
    // Pairs are packed row by row: (0,1),(0,2)..(0,d-1),(1,2),...
    function automatic int rnd_idx(input int d, input int i, input int j);
        return i * d - i * (i + 1) / 2 + (j - 1 - i);
    endfunction

    // Bit position of share i of lane l in a W*d sharing vector.
    function automatic int sh_idx(input int l, input int i, input int d);
        return l * d + i;
    endfunction

endpackage
`default_nettype wire

// File: rtl/msk_pipe_slice.sv
`default_nettype none
// ============================================================================
// Module   : msk_pipe_slice
// Purpose  : One valid/ready register slice. Loads when empty or when its
//            contents leave in the same cycle; holds data while stalled.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            in_valid_i      - upstream data valid
//            in_ready_o      - slice can take data this cycle
//            in_data_i       - upstream data
//            out_valid_o     - slice holds valid data
//            out_ready_i     - downstream takes data this cycle
//            out_data_o      - registered data
// Revision : 1.0 - initial release
// ============================================================================
module msk_pipe_slice #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic             load;

    // Ready also when the current word leaves now: zero-bubble pass-through.
    assign in_ready_o  = !valid_q || out_ready_i;
    assign load        = in_valid_i && in_ready_o;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= in_data_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/msk_and_dom_pipe.sv
`default_nettype none
// ============================================================================
// Module   : msk_and_dom_pipe
// Purpose  : W-lane DOM-indep masked AND for D shares, with a product
//            register stage (P), optional compressed-output stage (C) and
//            valid/ready flow control. Randomness is consumed only on fire.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            ina_i, inb_i          - operand sharings, lane l share i at l*D+i
//            in_valid_i/in_ready_o - operand handshake
//            rnd_i                 - fresh randomness, W*D*(D-1)/2 bits
//            rnd_valid_i/rnd_ready_o - randomness handshake
//            out_o                 - result sharing, same layout as ina_i
//            out_valid_o/out_ready_i - result handshake
// Revision : 1.0 - initial release
// ============================================================================
module msk_and_dom_pipe
    import msk_pkg::*;
#(
    parameter int D       = 2,
    parameter int W       = 8,
    parameter int OUT_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [W*D-1:0]          ina_i,
    input  logic [W*D-1:0]          inb_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [W*n_rnd(D)-1:0]   rnd_i,
    input  logic                    rnd_valid_i,
    output logic                    rnd_ready_o,
    output logic [W*D-1:0]          out_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i
);

    localparam int R = n_rnd(D);

    if (D < 2) begin : g_bad_d
        $error("msk_and_dom_pipe: D must be at least 2");
    end

    logic             fire;
    logic             p_valid;
    logic             p_out_ready;
    logic [W*D*D-1:0] prod_d;
    logic [W*D*D-1:0] prod_q;
    logic [W*D-1:0]   comp;

    assign fire        = in_valid_i && rnd_valid_i && in_ready_o;
    // Randomness is popped exactly when the operands are; the source must
    // gate its own pop with rnd_valid.
    assign rnd_ready_o = in_valid_i && in_ready_o;

    // Cross-domain products refreshed with r(i,j) = r(j,i); inner-domain
    // products are left unrefreshed. Product (l,i,j) sits at (l*D+i)*D+j.
    for (genvar l = 0; l < W; l++) begin : g_lane
        for (genvar i = 0; i < D; i++) begin : g_i
            for (genvar j = 0; j < D; j++) begin : g_j
                if (i == j) begin : g_inner
                    assign prod_d[sh_idx(l, i, D)*D+j] =
                        ina_i[sh_idx(l, i, D)] & inb_i[sh_idx(l, j, D)];
                end else if (i < j) begin : g_upper
                    assign prod_d[sh_idx(l, i, D)*D+j] =
                        (ina_i[sh_idx(l, i, D)] & inb_i[sh_idx(l, j, D)])
                        ^ rnd_i[l*R+rnd_idx(D, i, j)];
                end else begin : g_lower
                    assign prod_d[sh_idx(l, i, D)*D+j] =
                        (ina_i[sh_idx(l, i, D)] & inb_i[sh_idx(l, j, D)])
                        ^ rnd_i[l*R+rnd_idx(D, j, i)];
                end
            end
        end
    end

    msk_pipe_slice #(
        .WIDTH (W*D*D)
    ) u_stage_p (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (fire),
        .in_ready_o  (in_ready_o),
        .in_data_i   (prod_d),
        .out_valid_o (p_valid),
        .out_ready_i (p_out_ready),
        .out_data_o  (prod_q)
    );

    // Compression only ever sees registered products, so the glitchy
    // combinational products never mix with each other.
    always_comb begin
        comp = '0;
        for (int l = 0; l < W; l++) begin
            for (int i = 0; i < D; i++) begin
                for (int j = 0; j < D; j++) begin
                    comp[l*D+i] = comp[l*D+i] ^ prod_q[(l*D+i)*D+j];
                end
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        msk_pipe_slice #(
            .WIDTH (W*D)
        ) u_stage_c (
            .clk         (clk),
            .rst         (rst),
            .in_valid_i  (p_valid),
            .in_ready_o  (p_out_ready),
            .in_data_i   (comp),
            .out_valid_o (out_valid_o),
            .out_ready_i (out_ready_i),
            .out_data_o  (out_o)
        );
    end else begin : g_out_comb
        assign out_o       = comp;
        assign out_valid_o = p_valid;
        assign p_out_ready = out_ready_i;
    end

endmodule
`default_nettype wire
